ram_dx_be: RTL and testbench

Simulation-model dual-port synchronous RAM with per-byte write masks, selectable read latency (1 or 2 cycles) and a defined cross-port collision policy. It is the next generation of the single-port simulation RAM used behind the core and cache models. It keeps the registered-request, zero-when-idle read-bus behaviour of the single-port model and adds a second independent port, byte-granular writes and collision reporting.

---
 rtl/ram_dx_be.sv | 111 +++++++++++
 tb/tb_ram_dx_be.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_dx_be.sv
// ram_dx_be: dual-port simulation RAM with per-byte write masks, 1- or 2-cycle
// read latency, selectable cross-port read policy and same-address collision flag.
module ram_dx_be #(
    parameter int CAddrLen = 13,
    parameter int CDataLen = 128,
    parameter int CRdLat   = 1,
    parameter bit CWrFirst = 1'b1
) (
    input  logic                  AClkH,
    input  logic                  AResetH,
    input  logic                  AClkHEn,
    input  logic [CAddrLen-1:0]   AAddrA,
    input  logic [CAddrLen-1:0]   AAddrB,
    input  logic [CDataLen-1:0]   AMosiA,
    input  logic [CDataLen-1:0]   AMosiB,
    input  logic [CDataLen/8-1:0] AWrMaskA,
    input  logic [CDataLen/8-1:0] AWrMaskB,
    input  logic                  AWrEnA,
    input  logic                  AWrEnB,
    input  logic                  ARdEnA,
    input  logic                  ARdEnB,
    output logic [CDataLen-1:0]   AMisoA,
    output logic [CDataLen-1:0]   AMisoB,
    output logic                  ACollision
);
    localparam int CMaskLen = CDataLen / 8;
    localparam int CDepth   = 1 << CAddrLen;

    logic [CDataLen-1:0] r_mem [CDepth];
    logic [CAddrLen-1:0] r_addr_a, r_addr_b;
    logic [CDataLen-1:0] r_data_a, r_data_b;
    logic [CMaskLen-1:0] r_mask_a, r_mask_b;
    logic                r_we_a, r_we_b, r_re_a, r_re_b;
    logic                w_same;
    logic [CDataLen-1:0] w_rd_a, w_rd_b, w_l1_a, w_l1_b;

    always_ff @(posedge AClkH or posedge AResetH) begin
        if (AResetH) begin
            r_addr_a <= '0;
            r_addr_b <= '0;
            r_data_a <= '0;
            r_data_b <= '0;
            r_mask_a <= '0;
            r_mask_b <= '0;
            r_we_a   <= 1'b0;
            r_we_b   <= 1'b0;
            r_re_a   <= 1'b0;
            r_re_b   <= 1'b0;
        end else if (AClkHEn) begin
            // an idle port keeps its last address
            if (AWrEnA || ARdEnA) r_addr_a <= AAddrA;
            if (AWrEnB || ARdEnB) r_addr_b <= AAddrB;
            r_data_a <= AMosiA;
            r_data_b <= AMosiB;
            r_mask_a <= AWrMaskA;
            r_mask_b <= AWrMaskB;
            r_we_a   <= AWrEnA;
            r_we_b   <= AWrEnB;
            r_re_a   <= ARdEnA;
            r_re_b   <= ARdEnB;
        end
    end

    // port B's bytes are assigned last so B wins on overlapping bytes
    always_ff @(posedge AClkH or posedge AResetH) begin
        if (AResetH) begin
            for (int i = 0; i < CDepth; i++) r_mem[i] <= '0;
        end else if (AClkHEn) begin
            for (int i = 0; i < CMaskLen; i++)
                if (r_we_a && r_mask_a[i]) r_mem[r_addr_a][8*i +: 8] <= r_data_a[8*i +: 8];
            for (int i = 0; i < CMaskLen; i++)
                if (r_we_b && r_mask_b[i]) r_mem[r_addr_b][8*i +: 8] <= r_data_b[8*i +: 8];
        end
    end

    assign w_same = r_addr_a == r_addr_b;

    always_comb begin
        w_rd_a = r_mem[r_addr_a];
        w_rd_b = r_mem[r_addr_b];
        for (int i = 0; i < CMaskLen; i++) begin
            if (CWrFirst && w_same && r_we_b && r_mask_b[i]) w_rd_a[8*i +: 8] = r_data_b[8*i +: 8];
            if (CWrFirst && w_same && r_we_a && r_mask_a[i]) w_rd_b[8*i +: 8] = r_data_a[8*i +: 8];
        end
    end

    assign w_l1_a     = r_re_a ? w_rd_a : '0;
    assign w_l1_b     = r_re_b ? w_rd_b : '0;
    assign ACollision = w_same && ((r_we_a && (r_we_b || r_re_b)) || (r_we_b && r_re_a));

    generate
        if (CRdLat == 2) begin : g_lat2
            logic [CDataLen-1:0] r_out_a, r_out_b;
            always_ff @(posedge AClkH or posedge AResetH) begin
                if (AResetH) begin
                    r_out_a <= '0;
                    r_out_b <= '0;
                end else if (AClkHEn) begin
                    r_out_a <= w_l1_a;
                    r_out_b <= w_l1_b;
                end
            end
            assign AMisoA = r_out_a;
            assign AMisoB = r_out_b;
        end else begin : g_lat1
            assign AMisoA = w_l1_a;
            assign AMisoB = w_l1_b;
        end
    endgenerate

endmodule

// File: tb/tb_ram_dx_be.sv
// tb_ram_dx_be: two RAM configurations (lat1/write-first, lat2/old-data) driven in
// lockstep and compared against a transaction-level memory model.
module tb_ram_dx_be;
    localparam int AW = 4;
    localparam int DW = 32;
    localparam int MW = DW / 8;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [MW-1:0] m;
        logic          w;
        logic          r;
    } req_t;

    logic          clk = 1'b0;
    logic          rst, en;
    logic [AW-1:0] aa, ab;
    logic [DW-1:0] da, db;
    logic [MW-1:0] ma, mb;
    logic          wa, wb, ra, rb;
    logic [DW-1:0] qa1, qb1, qa2, qb2;
    logic          col1, col2;

    logic [DW-1:0] mem [16];
    req_t          q [2];
    logic [DW-1:0] o2 [2];
    int            n = 0;
    int            errs = 0;

    always #5 clk = ~clk;

    ram_dx_be #(.CAddrLen(AW), .CDataLen(DW), .CRdLat(1), .CWrFirst(1'b1)) u1 (
        .AClkH(clk), .AResetH(rst), .AClkHEn(en),
        .AAddrA(aa), .AAddrB(ab), .AMosiA(da), .AMosiB(db),
        .AWrMaskA(ma), .AWrMaskB(mb), .AWrEnA(wa), .AWrEnB(wb),
        .ARdEnA(ra), .ARdEnB(rb), .AMisoA(qa1), .AMisoB(qb1), .ACollision(col1)
    );

    ram_dx_be #(.CAddrLen(AW), .CDataLen(DW), .CRdLat(2), .CWrFirst(1'b0)) u2 (
        .AClkH(clk), .AResetH(rst), .AClkHEn(en),
        .AAddrA(aa), .AAddrB(ab), .AMosiA(da), .AMosiB(db),
        .AWrMaskA(ma), .AWrMaskB(mb), .AWrEnA(wa), .AWrEnB(wb),
        .ARdEnA(ra), .ARdEnB(rb), .AMisoA(qa2), .AMisoB(qb2), .ACollision(col2)
    );

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rd(input int p, input bit wf);
        logic [DW-1:0] v;
        int o = 1 - p;
        if (!q[p].r) return '0;
        v = mem[q[p].a];
        if (wf && q[o].w && q[o].a == q[p].a)
            for (int i = 0; i < MW; i++) if (q[o].m[i]) v[8*i +: 8] = q[o].d[8*i +: 8];
        return v;
    endfunction

    function automatic logic colf();
        return q[0].a == q[1].a && ((q[0].w && (q[1].w || q[1].r)) || (q[1].w && (q[0].w || q[0].r)));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mem[i] = '0;
        for (int p = 0; p < 2; p++) begin
            q[p] = '{a: '0, d: '0, m: '0, w: 1'b0, r: 1'b0};
            o2[p] = '0;
        end
    endtask

    task automatic check_all();
        chk("qa1", qa1, rd(0, 1'b1));
        chk("qb1", qb1, rd(1, 1'b1));
        chk("qa2", qa2, o2[0]);
        chk("qb2", qb2, o2[1]);
        chk("col1", {31'b0, col1}, {31'b0, colf()});
        chk("col2", {31'b0, col2}, {31'b0, colf()});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (rst) model_reset();
        else if (en) begin
            for (int p = 0; p < 2; p++) o2[p] = rd(p, 1'b0);
            for (int p = 0; p < 2; p++)
                if (q[p].w)
                    for (int i = 0; i < MW; i++) if (q[p].m[i]) mem[q[p].a][8*i +: 8] = q[p].d[8*i +: 8];
            q[0] = '{a: (wa || ra) ? aa : q[0].a, d: da, m: ma, w: wa, r: ra};
            q[1] = '{a: (wb || rb) ? ab : q[1].a, d: db, m: mb, w: wb, r: rb};
        end
        check_all();
    endtask

    task automatic set_a(input logic w, input logic r, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [MW-1:0] m);
        wa = w; ra = r; aa = a; da = d; ma = m;
    endtask

    task automatic set_b(input logic w, input logic r, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [MW-1:0] m);
        wb = w; rb = r; ab = a; db = d; mb = m;
    endtask

    task automatic idle();
        set_a(1'b0, 1'b0, AW'($urandom), DW'($urandom), MW'($urandom));
        set_b(1'b0, 1'b0, AW'($urandom), DW'($urandom), MW'($urandom));
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        en  = 1'b1;
        idle();
        #1;
        check_all();
        cyc();
        cyc();
        rst = 1'b0;

        set_a(1'b0, 1'b1, 4'd3, '0, '0);
        cyc();
        chk("tp_rd3", qa1, 32'h0);
        idle();
        cyc();
        chk("tp_idle", qa1, 32'h0);

        set_a(1'b1, 1'b0, 4'd5, 32'hAABBCCDD, 4'hF);
        cyc();
        set_a(1'b1, 1'b0, 4'd5, 32'h11223344, 4'h5);
        cyc();
        idle();
        set_b(1'b0, 1'b1, 4'd5, '0, '0);
        cyc();
        chk("tp_mask_l1", qb1, 32'hAA22CC44);
        idle();
        cyc();
        chk("tp_mask_l2", qb2, 32'hAA22CC44);

        set_a(1'b1, 1'b0, 4'd7, 32'h11111111, 4'hF);
        set_b(1'b1, 1'b0, 4'd7, 32'h22222222, 4'h3);
        cyc();
        chk("tp_ww_col", {31'b0, col1}, 32'h1);
        idle();
        set_a(1'b0, 1'b1, 4'd7, '0, '0);
        cyc();
        chk("tp_ww_data", qa1, 32'h11112222);

        set_a(1'b1, 1'b0, 4'd2, 32'hDEADBEEF, 4'hF);
        set_b(1'b0, 1'b1, 4'd2, '0, '0);
        cyc();
        chk("tp_wf1", qb1, 32'hDEADBEEF);
        chk("tp_wr_col", {31'b0, col2}, 32'h1);
        idle();
        cyc();
        chk("tp_wf0", qb2, 32'h0);

        set_a(1'b0, 1'b1, 4'd5, '0, '0);
        cyc();
        chk("tp_l2_k1", qa2, 32'h0);
        idle();
        cyc();
        chk("tp_l2_k2", qa2, 32'hAA22CC44);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("tp_hold", qa2, 32'hAA22CC44);
        end
        en = 1'b1;

        set_a(1'b1, 1'b0, 4'd9, 32'hFFFFFFFF, 4'hF);
        cyc();
        rst = 1'b1;
        idle();
        #1;
        model_reset();
        check_all();
        cyc();
        rst = 1'b0;
        set_a(1'b0, 1'b1, 4'd9, '0, '0);
        cyc();
        chk("tp_rst_wr", qa1, 32'h0);

        for (int k = 0; k < 600; k++) begin
            rst = ($urandom_range(0, 99) == 0);
            en  = ($urandom_range(0, 7) != 0);
            set_a(1'($urandom), 1'($urandom), AW'($urandom_range(0, 3)), DW'($urandom), MW'($urandom));
            set_b(1'($urandom), 1'($urandom), AW'($urandom_range(0, 3)), DW'($urandom), MW'($urandom));
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n, errs);
        $finish;
    end
endmodule
